qsub_pipe: RTL and testbench

- Two-stage pipelined fixed-point subtractor, c = a - b, for the sign-magnitude Q format used by the datapath (bit N-1 = sign, bits N-2:0 = magnitude, Q fractional bits).
- Complements the combinational sign-magnitude adder. Used where inverse-kinematics stages stream operand pairs under valid/ready flow control.
- Adds two things the adder does not provide: saturation with an overflow flag, and full-throughput backpressure handling.

---
 rtl/qsub_pipe_if.sv | 25 ++
 rtl/qsub_pipe.sv | 112 +++++++++++
 tb/tb_qsub_pipe.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qsub_pipe_if.sv
// Operand/result stream bundle for the pipelined sign-magnitude subtractor.
// The master side supplies operand pairs and the downstream ready; the
// slave side (the subtractor) returns results, overflow and its own ready.
interface qsub_pipe_if #(
    parameter int N = 32
);
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_c;
    logic         o_overflow;

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_c, o_overflow
    );

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_c, o_overflow
    );
endinterface

// File: rtl/qsub_pipe.sv
// Two-stage pipelined sign-magnitude subtractor, c = a - b, with magnitude
// saturation and a full-throughput valid/ready pipeline.
// Stage 1 splits operands into magnitude/sign (subtrahend sign inverted) and
// precomputes the magnitude comparison; stage 2 does the add-or-subtract,
// saturates, normalises negative zero and holds the result register.
module qsub_pipe #(
    parameter int Q = 15,   // fractional bits; the arithmetic is format-agnostic
    parameter int N = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    qsub_pipe_if.slave  bus
);
    localparam int M = N - 1;   // magnitude width

    // Pipeline occupancy
    logic         s1_valid_reg;
    logic         s2_valid_reg;
    logic         adv1;
    logic         adv2;

    // Stage 1 registers
    logic [M-1:0] ma_reg;
    logic [M-1:0] mb_reg;
    logic         sa_reg;
    logic         sb_reg;        // already-inverted subtrahend sign
    logic         gt_reg;

    // Stage 2 result registers and their combinational inputs
    logic [N-1:0] c_reg;
    logic         ovf_reg;
    logic [N-1:0] c_next;
    logic         ovf_next;
    logic [N-1:0] sum_next;
    logic [M-1:0] mag_next;
    logic         sign_next;

    // A stage may move when the stage after it is empty or draining.
    // o_ready depends on i_ready and occupancy only, never on i_valid.
    assign adv2 = !s2_valid_reg || bus.i_ready;
    assign adv1 = !s1_valid_reg || adv2;

    assign bus.o_ready    = adv1;
    assign bus.o_valid    = s2_valid_reg;
    assign bus.o_c        = c_reg;
    assign bus.o_overflow = ovf_reg;

    // Stage 1: capture operand split and magnitude comparison
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_reg <= 1'b0;
            ma_reg       <= '0;
            mb_reg       <= '0;
            sa_reg       <= 1'b0;
            sb_reg       <= 1'b0;
            gt_reg       <= 1'b0;
        end else if (adv1) begin
            s1_valid_reg <= bus.i_valid;
            ma_reg       <= bus.i_a[M-1:0];
            mb_reg       <= bus.i_b[M-1:0];
            sa_reg       <= bus.i_a[N-1];
            sb_reg       <= ~bus.i_b[N-1];
            gt_reg       <= (bus.i_a[M-1:0] > bus.i_b[M-1:0]);
        end
    end

    // Stage 2 arithmetic: like signs add magnitudes, unlike signs subtract
    // the smaller from the larger and take the larger operand's sign.
    always_comb begin
        sum_next  = {1'b0, ma_reg} + {1'b0, mb_reg};
        mag_next  = '0;
        sign_next = 1'b0;
        ovf_next  = 1'b0;
        if (sa_reg == sb_reg) begin
            sign_next = sa_reg;
            if (sum_next[N-1]) begin
                mag_next = '1;
                ovf_next = 1'b1;
            end else begin
                mag_next = sum_next[M-1:0];
            end
        end else if (gt_reg) begin
            mag_next  = ma_reg - mb_reg;
            sign_next = sa_reg;
        end else begin
            mag_next  = mb_reg - ma_reg;
            sign_next = sb_reg;
        end
        // A zero magnitude is always reported as +0.
        if (mag_next == '0) begin
            sign_next = 1'b0;
        end
        c_next = {sign_next, mag_next};
    end

    // Stage 2 register: result loads only for a real operand, so the output
    // holds steady while stalled and across bubbles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid_reg <= 1'b0;
            c_reg        <= '0;
            ovf_reg      <= 1'b0;
        end else if (adv2) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                c_reg   <= c_next;
                ovf_reg <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_qsub_pipe.sv
// Directed self-checking bench for qsub_pipe. Inputs are driven 1 time unit
// after each rising edge and outputs are sampled at the same point.
// An operand presented in sample slot S_i shows up on the output at S_(i+2).
module tb_qsub_pipe;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    qsub_pipe_if #(.N(N)) bus ();

    qsub_pipe #(.Q(15), .N(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic rdy);
        bus.i_valid = v;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_ready = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        tick();
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_c !== 32'h0 || bus.o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%b c=%h ovf=%b, want 0 00000000 0",
                     bus.o_valid, bus.o_c, bus.o_overflow);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: o_ready=%b, want 1", bus.o_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        drive(1'b1, 32'h0001_8000, 32'h0000_8000, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: o_valid=%b one edge after issue, want 0", bus.o_valid);
        end
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_c !== 32'h0001_0000 || bus.o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic: valid=%b c=%h ovf=%b, want 1 00010000 0",
                     bus.o_valid, bus.o_c, bus.o_overflow);
        end
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_dup: o_valid=%b after single result, want 0", bus.o_valid);
        end
        $display("test_basic: 3.0 - 1.0 -> %h", 32'h0001_0000);
    endtask

    task automatic test_signs();
        logic [N-1:0] va [4];
        logic [N-1:0] vb [4];
        logic [N-1:0] ec [4];
        va = '{32'h0000_8000, 32'h8000_8000, 32'h0000_8000, 32'h8002_0000};
        vb = '{32'h0001_8000, 32'h0000_8000, 32'h8000_8000, 32'h8007_0000};
        ec = '{32'h8001_0000, 32'h8001_0000, 32'h0001_0000, 32'h0005_0000};
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (bus.o_valid !== 1'b1 || bus.o_c !== ec[i-2] || bus.o_overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL signs[%0d]: valid=%b c=%h ovf=%b, want 1 %h 0",
                             i - 2, bus.o_valid, bus.o_c, bus.o_overflow, ec[i-2]);
                end else begin
                    $display("signs[%0d]: %h - %h -> %h", i - 2, va[i-2], vb[i-2], bus.o_c);
                end
            end
            if (i < 4) drive(1'b1, va[i], vb[i], 1'b1);
            else       drive(1'b0, '0, '0, 1'b1);
            tick();
        end
    endtask

    task automatic test_zero();
        logic [N-1:0] va [4];
        logic [N-1:0] vb [4];
        va = '{32'h0000_8000, 32'h8000_0000, 32'h8000_4000, 32'h0000_0000};
        vb = '{32'h0000_8000, 32'h0000_0000, 32'h8000_4000, 32'h8000_0000};
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (bus.o_valid !== 1'b1 || bus.o_c !== 32'h0 || bus.o_overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zero[%0d]: valid=%b c=%h ovf=%b, want 1 00000000 0",
                             i - 2, bus.o_valid, bus.o_c, bus.o_overflow);
                end else begin
                    $display("zero[%0d]: %h - %h -> %h", i - 2, va[i-2], vb[i-2], bus.o_c);
                end
            end
            if (i < 4) drive(1'b1, va[i], vb[i], 1'b1);
            else       drive(1'b0, '0, '0, 1'b1);
            tick();
        end
    endtask

    task automatic test_saturation();
        logic [N-1:0] va [4];
        logic [N-1:0] vb [4];
        logic [N-1:0] ec [4];
        logic         eo [4];
        va = '{32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h7FFF_FFFE};
        vb = '{32'h8000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8000_0001};
        ec = '{32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        eo = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (bus.o_valid !== 1'b1 || bus.o_c !== ec[i-2] || bus.o_overflow !== eo[i-2]) begin
                    n_fail++;
                    $display("FAIL sat[%0d]: valid=%b c=%h ovf=%b, want 1 %h %b",
                             i - 2, bus.o_valid, bus.o_c, bus.o_overflow, ec[i-2], eo[i-2]);
                end else begin
                    $display("sat[%0d]: %h - %h -> %h ovf=%b", i - 2, va[i-2], vb[i-2],
                             bus.o_c, bus.o_overflow);
                end
            end
            if (i < 4) drive(1'b1, va[i], vb[i], 1'b1);
            else       drive(1'b0, '0, '0, 1'b1);
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] va [4];
        logic [N-1:0] vb [4];
        logic [N-1:0] ec [4];
        logic         er [10];
        logic         ev [10];
        logic         rdy;
        int           sent = 0;
        int           rcv  = 0;
        va = '{32'h0003_0000, 32'h0001_0000, 32'h8002_0000, 32'h0005_0000};
        vb = '{32'h0001_0000, 32'h0004_0000, 32'h8007_0000, 32'h8001_0000};
        ec = '{32'h0002_0000, 32'h8003_0000, 32'h0005_0000, 32'h0006_0000};
        er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 10; c++) begin
            rdy = !(c >= 3 && c <= 5);
            if (sent < 4) drive(1'b1, va[sent], vb[sent], rdy);
            else          drive(1'b0, '0, '0, rdy);
            #1;
            n_checks++;
            if (bus.o_ready !== er[c]) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: o_ready=%b, want %b", c, bus.o_ready, er[c]);
            end
            n_checks++;
            if (bus.o_valid !== ev[c]) begin
                n_fail++;
                $display("FAIL bp_valid[%0d]: o_valid=%b, want %b", c, bus.o_valid, ev[c]);
            end
            if (bus.o_valid === 1'b1) begin
                n_checks++;
                if (rcv >= 4) begin
                    n_fail++;
                    $display("FAIL bp_extra[%0d]: unexpected result c=%h", c, bus.o_c);
                end else if (bus.o_c !== ec[rcv]) begin
                    n_fail++;
                    $display("FAIL bp_data[%0d]: c=%h, want %h (result %0d)", c, bus.o_c,
                             ec[rcv], rcv);
                end else begin
                    $display("bp cycle %0d: result %0d c=%h ready=%b", c, rcv, bus.o_c, rdy);
                end
                if (rdy) rcv++;
            end
            if (bus.i_valid === 1'b1 && bus.o_ready === 1'b1) sent++;
            tick();
        end
        n_checks++;
        if (rcv != 4 || sent != 4) begin
            n_fail++;
            $display("FAIL bp_count: sent=%0d received=%0d, want 4 4", sent, rcv);
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 32'h0003_0000, 32'h0001_0000, 1'b1);
        tick();
        drive(1'b1, 32'h0005_0000, 32'h0002_0000, 1'b1);
        tick();
        // Reset while two ops are in flight and a third is offered.
        rst = 1'b1;
        drive(1'b1, 32'h0007_0000, 32'h0001_0000, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_c !== 32'h0 || bus.o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: valid=%b c=%h ovf=%b, want 0 00000000 0",
                     bus.o_valid, bus.o_c, bus.o_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_ghost[%0d]: o_valid=%b c=%h, want 0", i, bus.o_valid,
                         bus.o_c);
            end
        end
        drive(1'b1, 32'h0000_0003, 32'h0000_0001, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_early: o_valid=%b, want 0", bus.o_valid);
        end
        tick();
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_c !== 32'h0000_0002 || bus.o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_next: valid=%b c=%h ovf=%b, want 1 00000002 0",
                     bus.o_valid, bus.o_c, bus.o_overflow);
        end else begin
            $display("midreset: post-reset op -> %h", bus.o_c);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_zero();
        test_saturation();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
